// File: rtl/adsr_env_gen.sv
// ADSR envelope generator: steps an Attack/Decay/Sustain/Release level once per rising edge
// of an asynchronous rate tick. Optional exponential release tail: define ADSR_EXP_RELEASE_EN.
module adsr_env_gen #(
    parameter int WIDTH  = 8,
    parameter int RATE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_in,
    input  logic              gate,
    input  logic [RATE_W-1:0] attack,
    input  logic [RATE_W-1:0] decay,
    input  logic [WIDTH-1:0]  sustain,
    // "release" is a reserved word in SystemVerilog, hence release_rate
    input  logic [RATE_W-1:0] release_rate,
    output logic [WIDTH-1:0]  env_out,
    output logic [2:0]        state_out,
    output logic              busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    localparam logic [WIDTH:0] MAX_EXT = {1'b0, {WIDTH{1'b1}}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lvl_q, lvl_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic             step;

    logic [WIDTH:0]   lvl_ext;
    logic [WIDTH:0]   sus_ext;
    logic [WIDTH:0]   attack_ext;
    logic [WIDTH:0]   decay_ext;
    logic [WIDTH:0]   rel_ext;
    logic [WIDTH:0]   rel_dec;
    logic [WIDTH:0]   sum_att;
    logic [WIDTH:0]   diff_dec;
    logic [WIDTH:0]   diff_rel;

    assign lvl_ext    = {1'b0, lvl_q};
    assign sus_ext    = {1'b0, sustain};
    assign attack_ext = {{(WIDTH + 1 - RATE_W){1'b0}}, attack};
    assign decay_ext  = {{(WIDTH + 1 - RATE_W){1'b0}}, decay};
    assign rel_ext    = {{(WIDTH + 1 - RATE_W){1'b0}}, release_rate};

`ifdef ADSR_EXP_RELEASE_EN
    logic [WIDTH:0] rel_shifted;
    // Decrement proportional to level, never below 1 so the tail always reaches 0
    assign rel_shifted = lvl_ext >> rel_ext[3:0];
    assign rel_dec     = (rel_shifted == '0) ? {{WIDTH{1'b0}}, 1'b1} : rel_shifted;
`else
    assign rel_dec     = rel_ext;
`endif

    assign sum_att  = lvl_ext + attack_ext;
    assign diff_dec = lvl_ext - decay_ext;
    assign diff_rel = lvl_ext - rel_dec;

    // Two-flop synchroniser plus edge detector: one step per tick_in rising edge
    always_comb begin
        sync1_d = tick_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        step    = sync2_q & ~prev_q;
    end

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        case (state_q)
            ST_IDLE: begin
                lvl_d = '0;
                if (gate) begin
                    state_d = ST_ATTACK;
                end
            end
            ST_ATTACK: begin
                if (!gate) begin
                    state_d = ST_RELEASE;
                end else if (step) begin
                    if (sum_att >= MAX_EXT) begin
                        lvl_d   = MAX_EXT[WIDTH-1:0];
                        state_d = ST_DECAY;
                    end else begin
                        lvl_d = sum_att[WIDTH-1:0];
                    end
                end
            end
            ST_DECAY: begin
                if (!gate) begin
                    state_d = ST_RELEASE;
                end else if (step) begin
                    // Underflow or crossing the sustain floor both land exactly on sustain
                    if (diff_dec[WIDTH] || (diff_dec <= sus_ext)) begin
                        lvl_d   = sustain;
                        state_d = ST_SUSTAIN;
                    end else begin
                        lvl_d = diff_dec[WIDTH-1:0];
                    end
                end
            end
            ST_SUSTAIN: begin
                if (!gate) begin
                    state_d = ST_RELEASE;
                end else if (step) begin
                    lvl_d = sustain;
                end
            end
            ST_RELEASE: begin
                if (gate) begin
                    state_d = ST_ATTACK;
                end else if (step) begin
                    if (diff_rel[WIDTH] || (diff_rel == '0)) begin
                        lvl_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        lvl_d = diff_rel[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                lvl_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lvl_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign env_out   = lvl_q;
    assign state_out = state_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adsr_env_gen.sv
// Directed bench for adsr_env_gen (default linear-release build, WIDTH=8, RATE_W=8).
module tb_adsr_env_gen;

    logic       clk;
    logic       rst;
    logic       tick_in;
    logic       gate;
    logic [7:0] attack;
    logic [7:0] decay;
    logic [7:0] sustain;
    logic [7:0] release_rate;
    logic [7:0] env_out;
    logic [2:0] state_out;
    logic       busy;

    int chk_cnt;
    int pass_cnt;

    adsr_env_gen #(.WIDTH(8), .RATE_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .tick_in(tick_in),
        .gate(gate),
        .attack(attack),
        .decay(decay),
        .sustain(sustain),
        .release_rate(release_rate),
        .env_out(env_out),
        .state_out(state_out),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Called at a negedge; returns at a negedge after the level has updated and tick is low again
    task automatic do_tick();
        tick_in = 1'b1;
        repeat (3) @(negedge clk);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        chk_cnt      = 0;
        pass_cnt     = 0;
        rst          = 1'b1;
        gate         = 1'b1;
        tick_in      = 1'b0;
        attack       = 8'd64;
        decay        = 8'd50;
        sustain      = 8'd100;
        release_rate = 8'd30;

        // Reset held with gate high and ticks toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tick_in = ~tick_in;
            check("rst_env", env_out, 0);
            check("rst_state", state_out, 0);
            check("rst_busy", busy, 0);
        end
        tick_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("gate_on_state", state_out, 1);
        check("gate_on_env", env_out, 0);
        check("gate_on_busy", busy, 1);

        // Attack
        do_tick(); check("att1", env_out, 64);  check("att1_state", state_out, 1);
        do_tick(); check("att2", env_out, 128);
        do_tick(); check("att3", env_out, 192);
        do_tick(); check("att4", env_out, 255); check("att4_state", state_out, 2);

        // Decay to sustain
        do_tick(); check("dec1", env_out, 205);
        do_tick(); check("dec2", env_out, 155);
        do_tick(); check("dec3", env_out, 105); check("dec3_state", state_out, 2);
        do_tick(); check("dec4", env_out, 100); check("dec4_state", state_out, 3);
        do_tick(); check("sus_hold", env_out, 100);

        // Gate off moves to release without a tick
        gate = 1'b0;
        @(negedge clk);
        check("rel_enter_state", state_out, 4);
        check("rel_enter_env", env_out, 100);
        do_tick(); check("rel1", env_out, 70);
        do_tick(); check("rel2", env_out, 40);
        do_tick(); check("rel3", env_out, 10);  check("rel3_busy", busy, 1);
        do_tick(); check("rel4", env_out, 0);   check("rel4_state", state_out, 0);
        check("rel4_busy", busy, 0);

        // Gate off coincident with a step in ATTACK at 128
        gate = 1'b1;
        @(negedge clk);
        check("att_again_state", state_out, 1);
        do_tick(); check("att_b1", env_out, 64);
        do_tick(); check("att_b2", env_out, 128);
        tick_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        gate = 1'b0;
        @(negedge clk);
        check("coinc_state", state_out, 4);
        check("coinc_env", env_out, 128);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
        check("coinc_after_env", env_out, 128);
        release_rate = 8'd88;
        do_tick(); check("rel_to_40", env_out, 40); check("rel_to_40_state", state_out, 4);

        // Retrigger from 40, with exact three-edge tick latency
        gate = 1'b1;
        @(negedge clk);
        check("retrig_state", state_out, 1);
        check("retrig_env", env_out, 40);
        tick_in = 1'b1;
        @(posedge clk); #1;
        check("lat_edge1", env_out, 40);
        @(posedge clk); #1;
        check("lat_edge2", env_out, 40);
        @(posedge clk); #1;
        check("lat_edge3", env_out, 104);
        @(negedge clk);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
        check("retrig_hold", env_out, 104);

        // Zero rate holds; constant tick changes nothing
        attack = 8'd0;
        do_tick(); check("rate0_env", env_out, 104); check("rate0_state", state_out, 1);
        repeat (10) @(negedge clk);
        check("idle_tick_env", env_out, 104);

        // Saturating attack, decay rate 0, large decay, sustain tracking
        attack = 8'd255;
        do_tick(); check("sat_env", env_out, 255); check("sat_state", state_out, 2);
        decay = 8'd0;
        do_tick(); check("dec0_env", env_out, 255); check("dec0_state", state_out, 2);
        decay = 8'd200;
        do_tick(); check("dec_big_env", env_out, 100); check("dec_big_state", state_out, 3);
        sustain = 8'd120;
        do_tick(); check("sus_track", env_out, 120);

        // Mid-envelope reset
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_env", env_out, 0);
        check("mid_rst_state", state_out, 0);
        check("mid_rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_state", state_out, 1);
        do_tick(); check("post_rst_att", env_out, 255); check("post_rst_att_state", state_out, 2);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
